// File: rtl/fb_pkg.sv
// fb_pkg: shared VGA timing, framebuffer geometry and pixel types for the scanout path.
package fb_pkg;

  // 640x480@60 horizontal timing, in pixel clocks
  localparam logic [9:0] H_VISIBLE = 10'd640;
  localparam logic [9:0] H_FRONT   = 10'd16;
  localparam logic [9:0] H_SYNC    = 10'd96;
  localparam logic [9:0] H_BACK    = 10'd48;
  localparam logic [9:0] H_TOTAL   = 10'd800;

  // Vertical timing, in lines
  localparam logic [9:0] V_VISIBLE = 10'd480;
  localparam logic [9:0] V_FRONT   = 10'd10;
  localparam logic [9:0] V_SYNC    = 10'd2;
  localparam logic [9:0] V_BACK    = 10'd33;
  localparam logic [9:0] V_TOTAL   = 10'd525;

  // Framebuffer is shown 2x scaled, horizontally centred
  localparam logic [9:0] FB_X_OFFSET = 10'd64;
  localparam logic [9:0] FB_WIDTH    = 10'd256;
  localparam logic [9:0] FB_HEIGHT   = 10'd240;

  // Derived window / sync edges (end values exclusive)
  localparam logic [9:0] FB_X_END = FB_X_OFFSET + (FB_WIDTH << 1);
  localparam logic [9:0] FB_Y_END = FB_HEIGHT << 1;
  localparam logic [9:0] HS_START = H_VISIBLE + H_FRONT;
  localparam logic [9:0] HS_END   = HS_START + H_SYNC;
  localparam logic [9:0] VS_START = V_VISIBLE + V_FRONT;
  localparam logic [9:0] VS_END   = VS_START + V_SYNC;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  // Grayscale colour for a 4-bit index
  function automatic rgb12_t gray12(input logic [3:0] i);
    return '{r: i, g: i, b: i};
  endfunction

endpackage

// File: rtl/fb_palette.sv
// fb_palette: 16x12 palette register file, grayscale at reset, registered read.
// Only instantiated when FB_SCANOUT_PALETTE_EN is defined. A same-cycle write and
// read of one entry returns the old colour.
module fb_palette
  import fb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       we_i,
  input  logic [3:0] waddr_i,
  input  logic [11:0] wdata_i,
  input  logic [3:0] raddr_i,
  output rgb12_t     rdata_o
);

  rgb12_t mem_q [16];
  rgb12_t rdata_q;

  // Entry storage and read register; read samples pre-write contents
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 16; i++) mem_q[i] <= gray12(4'(i));
      rdata_q <= '0;
    end else begin
      if (we_i) mem_q[waddr_i] <= rgb12_t'(wdata_i);
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: 640x480@60 VGA scanout of the 256x240x4 framebuffer, 2x scaled to 512x480
// and centred. Three-stage pipeline: counters/address, flags + FB data, colour + syncs.
// Owns the buffer-swap handshake (pulse at hc=0, vc=480).
// Build option FB_SCANOUT_PALETTE_EN: writable 16-entry palette; otherwise grayscale.
module fb_scanout
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 4,
  parameter logic [11:0] BORDER_COLOR = 12'h000
) (
  input  logic                  CLK,
  input  logic                  RESET,
  output logic [ADDR_WIDTH-1:0] FB_ADDR,
  input  logic [DATA_WIDTH-1:0] FB_DATA,
  input  logic                  SWAP_REQ,
  output logic                  FRAME_SWAP,
  output logic                  VBLANK,
  input  logic                  PAL_WE,
  input  logic [3:0]            PAL_ADDR,
  input  logic [11:0]           PAL_DATA,
  output logic                  HS,
  output logic                  VS,
  output logic                  BLANK,
  output logic [3:0]            RED,
  output logic [3:0]            GREEN,
  output logic [3:0]            BLUE
);

  // ---------------- stage 0: counters, address, swap ----------------
  logic [9:0] hc_q, hc_d, vc_q, vc_d;
  logic       pending_q, pending_d;
  logic       line_end, swap_pt;

  assign line_end = (hc_q == H_TOTAL - 10'd1);
  assign hc_d     = line_end ? '0 : hc_q + 10'd1;
  assign vc_d     = !line_end ? vc_q :
                    (vc_q == V_TOTAL - 10'd1) ? '0 : vc_q + 10'd1;

  // Swap fires at the first cycle of vblank if a request is pending or arrives now
  assign swap_pt    = (hc_q == '0) && (vc_q == V_VISIBLE);
  assign FRAME_SWAP = swap_pt && (pending_q || SWAP_REQ);
  assign pending_d  = FRAME_SWAP ? 1'b0 : (pending_q || SWAP_REQ);
  assign VBLANK     = (vc_q >= V_VISIBLE);

  // Raster counters and sticky swap request
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hc_q      <= '0;
      vc_q      <= '0;
      pending_q <= 1'b0;
    end else begin
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      pending_q <= pending_d;
    end
  end

  logic       vis0, win0, hs0, vs0;
  logic [9:0] x_off;

  assign vis0  = (hc_q < H_VISIBLE) && (vc_q < V_VISIBLE);
  assign win0  = (hc_q >= FB_X_OFFSET) && (hc_q < FB_X_END) && (vc_q < FB_Y_END);
  assign hs0   = !((hc_q >= HS_START) && (hc_q < HS_END));
  assign vs0   = !((vc_q >= VS_START) && (vc_q < VS_END));
  assign x_off = hc_q - FB_X_OFFSET;

  // Halving both coordinates gives the 2x pixel doubling
  assign FB_ADDR = win0 ? {vc_q[8:1], x_off[8:1]} : '0;

  // ---------------- stage 1: flags, FB data arrives ----------------
  logic vis1_q, win1_q, hs1_q, vs1_q;

  // Register stage-0 flags to line up with FB_DATA
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      vis1_q <= 1'b0;
      win1_q <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
    end else begin
      vis1_q <= vis0;
      win1_q <= win0;
      hs1_q  <= hs0;
      vs1_q  <= vs0;
    end
  end

  // ---------------- stage 2: colour, syncs to pins ----------------
  rgb12_t src_rgb;

`ifdef FB_SCANOUT_PALETTE_EN
  fb_palette u_pal (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .we_i    (PAL_WE),
    .waddr_i (PAL_ADDR),
    .wdata_i (PAL_DATA),
    .raddr_i (FB_DATA[3:0]),
    .rdata_o (src_rgb)
  );
`else
  rgb12_t gray_q;

  // Fixed grayscale: index replicated on all three channels
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) gray_q <= '0;
    else       gray_q <= {FB_DATA[3:0], FB_DATA[3:0], FB_DATA[3:0]};
  end

  assign src_rgb = gray_q;

  logic unused_pal;
  assign unused_pal = ^{PAL_WE, PAL_ADDR, PAL_DATA};
`endif

  logic vis2_q, win2_q, hs_q, vs_q, blank_q;

  // Final flag register, aligned with the colour source register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      vis2_q  <= 1'b0;
      win2_q  <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b1;
    end else begin
      vis2_q  <= vis1_q;
      win2_q  <= win1_q;
      hs_q    <= hs1_q;
      vs_q    <= vs1_q;
      blank_q <= !vis1_q;
    end
  end

  rgb12_t pix;

  // Pick palette / border / black from stage-2 registers
  always_comb begin
    pix = '0;
    if (vis2_q) pix = win2_q ? src_rgb : rgb12_t'(BORDER_COLOR);
  end

  assign HS    = hs_q;
  assign VS    = vs_q;
  assign BLANK = blank_q;
  assign RED   = pix.r;
  assign GREEN = pix.g;
  assign BLUE  = pix.b;

  logic unused_x;
  assign unused_x = ^{x_off[9], x_off[0]};

endmodule

// File: doc/fb_scanout.md
# fb_scanout

Display-side reader for the double-buffered framebuffer. Generates 640x480@60 VGA timing from one pixel-rate clock and issues read addresses for the 256x240 4-bit framebuffer, scaled 2x and centred as 512x480. Returns pixels through a 16-entry palette as 12-bit RGB, pipeline-aligned with sync and blank. Also owns the buffer-swap handshake with the renderer: it emits the one-cycle swap pulse at the start of vertical blank, which drives the framebuffer's select toggle.

## Interface
- `ADDR_WIDTH`, 16: framebuffer address width. Must be 16 (row bits [15:8], column bits [7:0]).
- `DATA_WIDTH`, 4: framebuffer pixel/palette index width.
- `BORDER_COLOR`, 12'h000: RGB shown in visible area outside the framebuffer window.
- `CLK` in 1: pixel clock (25 MHz); same clock as the framebuffer RAMs.
- `RESET` in 1: asynchronous, active-high reset.
- `FB_ADDR` out ADDR_WIDTH: read address to the framebuffer, combinational from the counters.
- `FB_DATA` in DATA_WIDTH: framebuffer read data, valid one cycle after `FB_ADDR`.
- `SWAP_REQ` in 1: renderer pulse, "back buffer complete".
- `FRAME_SWAP` out 1: one-cycle swap pulse to the framebuffer select toggle.
- `VBLANK` out 1: high while the vertical counter is 480 or more (undelayed).
- `PAL_WE` in 1: palette write enable.
- `PAL_ADDR` in 4: palette entry.
- `PAL_DATA` in 12: palette RGB {R,G,B}.
- `HS`, `VS` out 1: syncs, active low.
- `BLANK` out 1: high outside the 640x480 visible area.
- `RED`, `GREEN`, `BLUE` out 4 each: pixel colour.

## Operation
- Horizontal counter `hc` runs 0..799 and wraps to 0. Vertical counter `vc` increments when `hc` wraps and runs 0..524, then wraps.
- Visible area: `hc`<640 and `vc`<480.
- Sync pulses: HS low for `hc` 656..751; VS low for `vc` 490..491.
- Framebuffer window: `hc` 64..575 and `vc` 0..479.
  - x_fb = (hc-64)>>1, y_fb = vc>>1.
  - `FB_ADDR` = {y_fb[7:0], x_fb[7:0]}. Outside the window it is 0.
- Colour selection:
  - In window: palette[`FB_DATA`].
  - Visible but outside window: `BORDER_COLOR`.
  - Blank: 0.
- Swap handshake:
  - A `SWAP_REQ` pulse sets a sticky `pending` flag.
  - On the cycle with `hc`==0 and `vc`==480: if `pending` (or `SWAP_REQ` in that same cycle), `FRAME_SWAP`=1 for exactly that cycle and `pending` clears.
  - Otherwise no pulse, and the front buffer is shown again.
  - Multiple requests within one frame collapse into one swap.
- Palette writes take effect on the next clock edge. A write and a read of the same entry in the same cycle returns the old value.
- Reset values: `hc`=`vc`=0, `pending`=0, `FRAME_SWAP`=0, `HS`=`VS`=1, `BLANK`=1, RGB=0, pipeline flags cleared. Reset asserted mid-frame restarts timing from (0,0) on release.

## Timing
- Stage 0 (cycle t): counters valid, `FB_ADDR` driven.
- Stage 1 (t+1): `FB_DATA` valid. Window/visible/sync flags registered.
- Stage 2 (t+2): palette lookup registered. `RED`/`GREEN`/`BLUE`/`HS`/`VS`/`BLANK` all registered and mutually aligned.
- Latency: counter to pin is 2 cycles for every video output.
- `FRAME_SWAP` and `VBLANK` are not delayed.
- Frame period: 800x525 = 420000 cycles.

## Configuration
- `FB_SCANOUT_PALETTE_EN` defined: 16x12 palette register file, written via `PAL_*`. Reset contents are grayscale: entry i = {i,i,i}.
- Macro undefined: no palette storage, `PAL_*` ignored. Colour is fixed grayscale, `RED`=`GREEN`=`BLUE`=`FB_DATA`.
- Both builds give identical output at reset.

## Structure
- Package `fb_pkg`:
  - Constants H_VISIBLE/H_FRONT/H_SYNC/H_BACK/H_TOTAL (640/16/96/48/800) and V_VISIBLE/V_FRONT/V_SYNC/V_BACK/V_TOTAL (480/10/2/33/525).
  - FB_X_OFFSET=64, FB_WIDTH=256, FB_HEIGHT=240.
  - typedef `rgb12_t` as a packed struct {r,g,b} of 4 bits each.
- One sub-module, `fb_palette`: register file with write port and registered read. It is instantiated only under `FB_SCANOUT_PALETTE_EN`.

## Test plan
- Reset: assert `RESET` mid-frame, hold 3 cycles, then release.
  - During reset: `HS`=`VS`=1, `BLANK`=1, RGB=0, `FRAME_SWAP`=0.
  - First `HS` falling edge 658 cycles after release.
- Sync timing: run 2 frames.
  - HS low for 96 cycles per line. VS low for 1600 cycles. Period 420000.
- Addressing: at `hc`=65, `vc`=3, `FB_ADDR`=16'h0100. At `hc`=575, `vc`=479, `FB_ADDR`=16'hEFFF. At `hc`=600, `FB_ADDR`=0.
- Colour:
  - Model returns `FB_DATA`=4'hA → RGB=12'hAAA two cycles later, in grayscale or default palette.
  - Write PAL[4'hA]=12'hF00 → RGB=12'hF00.
  - Border pixel (`hc`=10, `vc`=10) → `BORDER_COLOR`.
- Swap:
  - Pulse `SWAP_REQ` twice during `vc`=100 → exactly one `FRAME_SWAP` at `vc`=480,`hc`=0, and none the next frame.
  - `SWAP_REQ` exactly at `vc`=480,`hc`=0 → `FRAME_SWAP` in that same cycle.
